// File: rtl/mic_shot_detect.sv
// Microphone shot detector: drains Audio_Controller samples, qualifies loud bursts into a one-cycle
// trigger with holdoff, and drives a decaying peak meter and shot counter. Define MIC_SHOT_HYST_EN
// to release a partial burst only below THRESH>>1 instead of below THRESH.
module mic_shot_detect #(
    parameter logic [7:0]  THRESH         = 8'd40,
    parameter int unsigned MIN_LOUD       = 4,
    parameter int unsigned HOLDOFF_CYCLES = 25000000,
    parameter int unsigned DECAY_CYCLES   = 500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       enable,
    input  logic       audio_in_available,
    input  logic [7:0] left_channel_audio_in,
    input  logic [7:0] right_channel_audio_in,
    output logic       read_audio_in,
    output logic       trigger,
    output logic       busy,
    output logic [7:0] peak,
    output logic [7:0] shot_count
);

    localparam int unsigned HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam int unsigned DW = $clog2(DECAY_CYCLES + 1);
    localparam logic [3:0]  MinLoud = 4'(MIN_LOUD);
`ifdef MIC_SHOT_HYST_EN
    localparam logic [7:0]  RelThresh = THRESH >> 1;
`else
    localparam logic [7:0]  RelThresh = THRESH;
`endif

    typedef enum logic [1:0] {StQuiet, StCount, StFire, StHoldoff} state_e;

    state_e        state_q;
    logic          rd_q;
    logic          mag_valid_q;
    logic [7:0]    mag_q;
    logic [7:0]    mag_d;
    logic [3:0]    loud_cnt_q;
    logic [HW-1:0] hold_q;
    logic [DW-1:0] decay_q;
    logic          decay_wrap;
    logic          trigger_q;
    logic          busy_q;
    logic [7:0]    peak_q;
    logic [7:0]    shot_q;
    logic          loud;

    // |x| of a signed byte, with -128 saturating to 127.
    function automatic logic [6:0] abs7(input logic [7:0] x);
        logic [7:0] neg;
        neg = ~x + 8'd1;
        if (x == 8'h80)  return 7'd127;
        else if (x[7])   return neg[6:0];
        else             return x[6:0];
    endfunction

    always_comb begin
        logic [6:0] al;
        logic [6:0] ar;
        al    = abs7(left_channel_audio_in);
        ar    = abs7(right_channel_audio_in);
        mag_d = {1'b0, (al > ar) ? al : ar};
    end

    // Reads at most every other clock so each pair is consumed exactly once.
    assign read_audio_in = audio_in_available & ~rd_q;
    assign loud          = (mag_q >= THRESH);
    assign decay_wrap    = (decay_q == DW'(DECAY_CYCLES - 1));

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            rd_q        <= 1'b0;
            mag_valid_q <= 1'b0;
            mag_q       <= 8'd0;
        end else begin
            rd_q        <= read_audio_in;
            mag_valid_q <= read_audio_in;
            if (read_audio_in) mag_q <= mag_d;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StQuiet;
            loud_cnt_q <= 4'd0;
            hold_q     <= '0;
            trigger_q  <= 1'b0;
            busy_q     <= 1'b0;
            shot_q     <= 8'd0;
        end else begin
            trigger_q <= 1'b0;
            busy_q    <= (state_q == StFire) || (state_q == StHoldoff);
            case (state_q)
                StQuiet: begin
                    if (mag_valid_q && enable && loud) begin
                        loud_cnt_q <= 4'd1;
                        state_q    <= (MinLoud == 4'd1) ? StFire : StCount;
                    end
                end
                StCount: begin
                    if (!enable) begin
                        loud_cnt_q <= 4'd0;
                        state_q    <= StQuiet;
                    end else if (mag_valid_q) begin
                        if (loud) begin
                            loud_cnt_q <= loud_cnt_q + 4'd1;
                            if (loud_cnt_q + 4'd1 == MinLoud) state_q <= StFire;
                        end else if (mag_q < RelThresh) begin
                            loud_cnt_q <= 4'd0;
                            state_q    <= StQuiet;
                        end
                    end
                end
                StFire: begin
                    trigger_q <= 1'b1;
                    shot_q    <= shot_q + 8'd1;
                    hold_q    <= HW'(HOLDOFF_CYCLES - 1);
                    state_q   <= StHoldoff;
                end
                StHoldoff: begin
                    if (hold_q == '0) begin
                        loud_cnt_q <= 4'd0;
                        state_q    <= StQuiet;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: state_q <= StQuiet;
            endcase
        end
    end

    // A peak load in the same cycle as a decay tick swallows the tick.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            decay_q <= '0;
            peak_q  <= 8'd0;
        end else begin
            decay_q <= decay_wrap ? '0 : decay_q + 1'b1;
            if (mag_valid_q && (mag_q > peak_q)) peak_q <= mag_q;
            else if (decay_wrap && (peak_q != 8'd0)) peak_q <= peak_q - 8'd1;
        end
    end

    assign trigger    = trigger_q;
    assign busy       = busy_q;
    assign peak       = peak_q;
    assign shot_count = shot_q;

endmodule

// File: tb/tb_mic_shot_detect.sv
// Directed bench for mic_shot_detect with shortened holdoff/decay; follows MIC_SHOT_HYST_EN.
module tb_mic_shot_detect;

    localparam int unsigned Hold  = 20;
    localparam int unsigned Decay = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic       avail = 1'b0;
    logic [7:0] lin = 8'd0;
    logic [7:0] rin = 8'd0;
    logic       rd;
    logic       trig;
    logic       busy;
    logic [7:0] peak;
    logic [7:0] shot;

    int tests = 0;
    int fails = 0;
    int trig_cnt = 0;
    int busy_cnt = 0;
    int rd_cnt = 0;

    mic_shot_detect #(
        .THRESH        (8'd40),
        .MIN_LOUD      (4),
        .HOLDOFF_CYCLES(Hold),
        .DECAY_CYCLES  (Decay)
    ) dut (
        .CLOCK_50              (clk),
        .resetn                (resetn),
        .enable                (enable),
        .audio_in_available    (avail),
        .left_channel_audio_in (lin),
        .right_channel_audio_in(rin),
        .read_audio_in         (rd),
        .trigger               (trig),
        .busy                  (busy),
        .peak                  (peak),
        .shot_count            (shot)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (trig) trig_cnt <= trig_cnt + 1;
        if (busy) busy_cnt <= busy_cnt + 1;
        if (rd)   rd_cnt   <= rd_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Presents one pair, waits (bounded) for the read, returns in the mag_valid cycle.
    task automatic send(input logic [7:0] lv, input logic [7:0] rv);
        int n;
        @(negedge clk);
        avail = 1'b1;
        lin   = lv;
        rin   = rv;
        #1;
        n = 0;
        while (!rd && n < 4) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!rd) chk("send_read", 32'(rd), 32'd1);
        @(negedge clk);
        avail = 1'b0;
    endtask

    task automatic burst4(input logic [7:0] lv);
        for (int i = 0; i < 4; i++) send(lv, 8'd0);
    endtask

    initial begin
        int t0;
        int b0;
        int r0;
        int exp_hyst;
`ifdef MIC_SHOT_HYST_EN
        exp_hyst = 1;
`else
        exp_hyst = 0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_read", 32'(rd), 32'd0);
        chk("rst_trig", 32'(trig), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_peak", 32'(peak), 32'd0);
        chk("rst_shot", 32'(shot), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Handshake: ten clocks of avail give alternating reads.
        r0 = rd_cnt;
        avail = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("hs_toggle", 32'(rd), (i % 2 == 0) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        avail = 1'b0;
        chk("hs_reads", 32'(rd_cnt - r0), 32'd5);
        repeat (3) @(negedge clk);

        // Burst fires two clocks after the 4th mag_valid; a second burst in holdoff is ignored.
        t0 = trig_cnt;
        b0 = busy_cnt;
        enable = 1'b1;
        burst4(8'd60);
        chk("trig_m0", 32'(trig), 32'd0);
        @(negedge clk);
        chk("trig_m1", 32'(trig), 32'd0);
        @(negedge clk);
        chk("trig_m2", 32'(trig), 32'd1);
        chk("busy_on", 32'(busy), 32'd1);
        chk("shot_1", 32'(shot), 32'd1);
        @(negedge clk);
        chk("trig_m3", 32'(trig), 32'd0);
        burst4(8'd60);
        repeat (40) @(negedge clk);
        chk("holdoff_trigs", 32'(trig_cnt - t0), 32'd1);
        chk("busy_len", 32'(busy_cnt - b0), 32'(Hold + 1));

        // Saturation and decay with detection disabled.
        t0 = trig_cnt;
        enable = 1'b0;
        send(8'h80, 8'd5);
        @(negedge clk);
        chk("sat_peak", 32'(peak), 32'd127);
        repeat (100) @(negedge clk);
        chk("decay_mid", 32'(peak >= 8'd113 && peak <= 8'd116), 32'd1);
        repeat (1000) @(negedge clk);
        chk("decay_zero", 32'(peak), 32'd0);

        // Disabled burst: reads and peak continue, no trigger.
        r0 = rd_cnt;
        burst4(8'd60);
        @(negedge clk);
        chk("dis_peak", 32'(peak), 32'd60);
        chk("dis_reads", 32'(rd_cnt - r0), 32'd4);
        repeat (10) @(negedge clk);
        chk("dis_trigs", 32'(trig_cnt - t0), 32'd0);

        // Interrupted burst: the 25 sample releases only without hysteresis.
        t0 = trig_cnt;
        enable = 1'b1;
        send(8'd60, 8'd0);
        send(8'd60, 8'd0);
        send(8'd25, 8'd0);
        send(8'd60, 8'd0);
        send(8'd60, 8'd0);
        repeat (10) @(negedge clk);
        chk("intr_trigs", 32'(trig_cnt - t0), 32'(exp_hyst));
        enable = 1'b0;
        repeat (30) @(negedge clk);
        enable = 1'b1;
        chk("intr_shot", 32'(shot), 32'(1 + exp_hyst));

        // Reset mid-holdoff, then a clean burst fires normally.
        t0 = trig_cnt;
        burst4(8'd60);
        repeat (5) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("mid_rst_trig", 32'(trig), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_peak", 32'(peak), 32'd0);
        chk("mid_rst_shot", 32'(shot), 32'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        burst4(8'd60);
        repeat (30) @(negedge clk);
        chk("post_rst_shot", 32'(shot), 32'd1);
        chk("post_rst_trigs", 32'(trig_cnt - t0), 32'd2);

        // Shot counter wraps on the 256th fire.
        for (int i = 0; i < 254; i++) begin
            burst4(8'd60);
            repeat (25) @(negedge clk);
        end
        chk("shot_255", 32'(shot), 32'd255);
        burst4(8'd60);
        repeat (25) @(negedge clk);
        chk("shot_wrap", 32'(shot), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mic_shot_detect.md
Name: mic_shot_detect

Overview:
- Consumer of the audio-in side of the Audio_Controller sample interface.
- Drains captured microphone samples through the audio_in_available / read_audio_in handshake and computes per-sample magnitude.
- Qualifies loud bursts into a single-cycle shot trigger, with a holdoff window between triggers.
- Also drives a decaying peak meter and a shot counter for LEDR display.
- The trigger feeds the game logic in place of, or alongside, the physical trigger input.

Parameters:
- THRESH, 8'd40: magnitude at or above which a sample is "loud".
- MIN_LOUD, 4: consecutive loud samples required to fire (1..15).
- HOLDOFF_CYCLES, 25000000: clocks of holdoff after a fire (0.5 s at 50 MHz).
- DECAY_CYCLES, 500000: clocks between peak meter decrements.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous active-low reset
- enable  in  1  detection enable; sample draining continues regardless
- audio_in_available  in  1  Audio_Controller has a sample pair
- left_channel_audio_in  in  8  signed two's-complement left sample
- right_channel_audio_in  in  8  signed two's-complement right sample
- read_audio_in  out  1  consume current sample pair
- trigger  out  1  one-cycle shot pulse
- busy  out  1  high in S_FIRE and S_HOLDOFF
- peak  out  8  peak-hold magnitude, 0..127
- shot_count  out  8  number of fires, wraps 255->0

Behaviour:
- Reset (async, resetn=0): all outputs 0; state S_QUIET; all counters 0; sample registers 0.
- Handshake:
  - read_audio_in = audio_in_available & ~rd_q, where rd_q is read_audio_in registered.
  - This gives at most one read per two clocks. A sample pair is latched on the cycle read_audio_in is high.
  - Draining happens in every state and with enable=0, so the controller FIFO never stalls.
- Magnitude (cycle N+1 after a read at cycle N):
  - |x| for 8-bit signed; -128 saturates to 127.
  - mag = max(|L|,|R|), registered. mag_valid pulses one cycle.
- State machine: updates on mag_valid, except S_FIRE and S_HOLDOFF, which are clock-driven.
  - S_QUIET:
    - enable & mag>=THRESH: loud_cnt=1.
    - If MIN_LOUD==1, go to S_FIRE; otherwise go to S_COUNT.
  - S_COUNT:
    - mag>=THRESH: loud_cnt++. When loud_cnt reaches MIN_LOUD, go to S_FIRE.
    - Release condition (see Optional Feature): loud_cnt=0, go to S_QUIET.
    - Otherwise hold loud_cnt.
    - enable=0: go to S_QUIET, loud_cnt=0.
  - S_FIRE (1 cycle):
    - trigger=1; shot_count++.
    - Load holdoff counter with HOLDOFF_CYCLES-1; go to S_HOLDOFF.
  - S_HOLDOFF:
    - Counter decrements every clock. At 0, go to S_QUIET with loud_cnt=0.
    - Loud samples are ignored. enable=0 does not abort holdoff.
- Latency: trigger is asserted 2 clocks after the mag_valid of the qualifying sample (state register, then registered output).
- Peak meter:
  - Decay counter free-runs 0..DECAY_CYCLES-1.
  - On mag_valid with mag>peak: peak=mag.
  - Else on decay wrap with peak>0: peak--.
  - If both occur in the same cycle, the load wins and the decay tick is lost.
- enable does not affect peak.

Optional Feature:
- Macro: MIC_SHOT_HYST_EN.
- Defined: release in S_COUNT happens only when mag < THRESH>>1. Samples in [THRESH>>1, THRESH) hold loud_cnt.
- Undefined: release happens when mag < THRESH.
- All other behaviour is identical.

Test Plan:
- Reset mid-holdoff: drive resetn low during S_HOLDOFF -> all outputs 0 immediately; state S_QUIET; next qualifying burst fires normally.
- Handshake: hold audio_in_available=1 for 10 clocks -> read_audio_in toggles 1,0,1,0..., giving exactly 5 reads.
- Burst: 4 pairs of L=8'd60, R=8'd0 with enable=1 -> exactly one trigger, 2 clocks after the 4th mag_valid; shot_count=1; busy high for HOLDOFF_CYCLES+1 clocks.
- Saturation: L=8'h80 (-128), R=8'd5 -> mag=127; peak=127; after 127*DECAY_CYCLES clocks with silent samples, peak=0.
- Interrupted burst: loud, loud, mag=25, loud, loud (THRESH=40):
  - Without MIC_SHOT_HYST_EN -> no trigger.
  - With MIC_SHOT_HYST_EN (25 >= 20 holds the count) -> trigger after the 5th sample.
- Holdoff and enable:
  - A second 4-sample burst during holdoff -> no trigger.
  - With enable=0, loud bursts -> no trigger, but read_audio_in continues and peak still updates.
  - shot_count wraps from 255 to 0 on the 256th fire.
